sequenciador_polinomio: RTL and testbench

SEQUENCIADOR_POLINOMIO -- requirements
Module: sequenciador_polinomio

---
 rtl/sequenciador_polinomio_if.sv | 38 +++
 rtl/sequenciador_polinomio.sv | 185 ++++++++++++++++++
 tb/tb_sequenciador_polinomio.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_polinomio_if.sv
// Signal bundle between the polynomial sequencer, its sample source,
// the external evaluator and the downstream result consumer.
interface sequenciador_polinomio_if;
    logic        coef_we;
    logic [1:0]  coef_sel;
    logic [15:0] coef_dado;
    logic        x_valid;
    logic [15:0] x_dado;
    logic        x_ready;
    logic        inicio;
    logic [15:0] X;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] C;
    logic        pronto;
    logic        overflow;
    logic [15:0] resultado;
    logic        r_valid;
    logic        r_ready;
    logic [15:0] r_dado;
    logic        r_ovf;
    logic        ocupado;
    logic [7:0]  contagem;

    modport slave (
        input  coef_we, coef_sel, coef_dado, x_valid, x_dado,
               pronto, overflow, resultado, r_ready,
        output x_ready, inicio, X, A, B, C, r_valid, r_dado, r_ovf,
               ocupado, contagem
    );

    modport master (
        output coef_we, coef_sel, coef_dado, x_valid, x_dado,
               pronto, overflow, resultado, r_ready,
        input  x_ready, inicio, X, A, B, C, r_valid, r_dado, r_ovf,
               ocupado, contagem
    );
endinterface

// File: rtl/sequenciador_polinomio.sv
// Sequences one polynomial evaluation per accepted sample through an external
// evaluator and queues {overflow, result} in a 2-entry FIFO.
module sequenciador_polinomio (
    input  logic                     ck,
    input  logic                     rst,
    sequenciador_polinomio_if.slave  bus
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DISPARA = 2'd1,
        ESPERA  = 2'd2,
        GRAVA   = 2'd3
    } estado_t;

    estado_t          estado_r;
    estado_t          estado_nx_s;
    logic             aceita_s;
    logic             captura_s;
    logic             grava_s;
    logic             coef_wr_s;
    logic             pop_s;

    logic [15:0]      x_r;
    logic [15:0]      a_r;
    logic [15:0]      b_r;
    logic [15:0]      c_r;
    logic             pronto_ant_r;
    logic [15:0]      res_r;
    logic             ovf_r;
    logic [7:0]       contagem_r;

    logic [1:0][16:0] mem_r;
    logic [1:0][16:0] mem_nx_s;
    logic             rd_r;
    logic             rd_nx_s;
    logic             wr_r;
    logic             wr_nx_s;
    logic [1:0]       cnt_r;
    logic [1:0]       cnt_nx_s;

    logic             inicio_r;
    logic             ocupado_r;
    logic             x_ready_r;
    logic             r_valid_r;
    logic [15:0]      r_dado_r;
    logic             r_ovf_r;

    // Coefficients are only writable while idle; selector 3 is a no-op.
    assign coef_wr_s = (estado_r == OCIOSO) && bus.coef_we;
    assign pop_s     = r_valid_r && bus.r_ready;

    // Next-state decode and one-cycle event strobes.
    always_comb begin
        estado_nx_s = estado_r;
        aceita_s    = 1'b0;
        captura_s   = 1'b0;
        grava_s     = 1'b0;
        case (estado_r)
            OCIOSO: begin
                if (bus.x_valid && x_ready_r) begin
                    aceita_s    = 1'b1;
                    estado_nx_s = DISPARA;
                end else begin
                    estado_nx_s = OCIOSO;
                end
            end
            DISPARA: estado_nx_s = ESPERA;
            ESPERA: begin
                // Only a fresh low-to-high edge of pronto counts as completion.
                if (bus.pronto && !pronto_ant_r) begin
                    captura_s   = 1'b1;
                    estado_nx_s = GRAVA;
                end else begin
                    estado_nx_s = ESPERA;
                end
            end
            GRAVA: begin
                grava_s     = 1'b1;
                estado_nx_s = OCIOSO;
            end
            default: estado_nx_s = OCIOSO;
        endcase
    end

    // Result FIFO next-state: simultaneous push and pop keeps occupancy.
    always_comb begin
        mem_nx_s = mem_r;
        rd_nx_s  = rd_r;
        wr_nx_s  = wr_r;
        cnt_nx_s = cnt_r;
        if (grava_s) begin
            mem_nx_s[wr_r] = {ovf_r, res_r};
            wr_nx_s        = ~wr_r;
        end else begin
            wr_nx_s = wr_r;
        end
        if (pop_s) begin
            rd_nx_s = ~rd_r;
        end else begin
            rd_nx_s = rd_r;
        end
        case ({grava_s, pop_s})
            2'b10:   cnt_nx_s = cnt_r + 2'd1;
            2'b01:   cnt_nx_s = cnt_r - 2'd1;
            default: cnt_nx_s = cnt_r;
        endcase
    end

    // State, operand and capture registers.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            estado_r     <= OCIOSO;
            x_r          <= 16'd0;
            a_r          <= 16'd0;
            b_r          <= 16'd0;
            c_r          <= 16'd0;
            pronto_ant_r <= 1'b0;
            res_r        <= 16'd0;
            ovf_r        <= 1'b0;
            contagem_r   <= 8'd0;
        end else begin
            estado_r     <= estado_nx_s;
            pronto_ant_r <= bus.pronto;
            if (aceita_s) begin
                x_r <= bus.x_dado;
            end
            if (coef_wr_s) begin
                case (bus.coef_sel)
                    2'd0:    a_r <= bus.coef_dado;
                    2'd1:    b_r <= bus.coef_dado;
                    2'd2:    c_r <= bus.coef_dado;
                    default: ;
                endcase
            end
            if (captura_s) begin
                res_r <= bus.resultado;
                ovf_r <= bus.overflow;
            end
            if (grava_s && (contagem_r != 8'hFF)) begin
                contagem_r <= contagem_r + 8'd1;
            end
        end
    end

    // FIFO storage and registered status outputs derived from next state.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            mem_r     <= '0;
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
            cnt_r     <= 2'd0;
            inicio_r  <= 1'b0;
            ocupado_r <= 1'b0;
            x_ready_r <= 1'b1;
            r_valid_r <= 1'b0;
            r_dado_r  <= 16'd0;
            r_ovf_r   <= 1'b0;
        end else begin
            mem_r     <= mem_nx_s;
            rd_r      <= rd_nx_s;
            wr_r      <= wr_nx_s;
            cnt_r     <= cnt_nx_s;
            inicio_r  <= (estado_nx_s == DISPARA);
            ocupado_r <= (estado_nx_s != OCIOSO);
            x_ready_r <= (estado_nx_s == OCIOSO) && (cnt_nx_s != 2'd2);
            r_valid_r <= (cnt_nx_s != 2'd0);
            r_dado_r  <= mem_nx_s[rd_nx_s][15:0];
            r_ovf_r   <= mem_nx_s[rd_nx_s][16];
        end
    end

    assign bus.x_ready  = x_ready_r;
    assign bus.inicio   = inicio_r;
    assign bus.X        = x_r;
    assign bus.A        = a_r;
    assign bus.B        = b_r;
    assign bus.C        = c_r;
    assign bus.r_valid  = r_valid_r;
    assign bus.r_dado   = r_dado_r;
    assign bus.r_ovf    = r_ovf_r;
    assign bus.ocupado  = ocupado_r;
    assign bus.contagem = contagem_r;

endmodule

// File: tb/tb_sequenciador_polinomio.sv
// Bench for sequenciador_polinomio: acts as sample source, evaluator and
// result consumer; expectations come from a polynomial model and a result queue.
module tb_sequenciador_polinomio;

    logic ck = 1'b0;
    logic rst;
    always #5 ck = ~ck;

    sequenciador_polinomio_if bus ();

    sequenciador_polinomio dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_aval   = 0;
    logic [15:0] ma, mb, mc;
    logic [16:0] fila[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_assert++;
        assert (obs === esp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Reference evaluator: A*X^2 + B*X + C, flagging results wider than 16 bits.
    function automatic logic [16:0] poli(input logic [15:0] x, a, b, c);
        longint unsigned t;
        t = 64'(a) * 64'(x) * 64'(x) + 64'(b) * 64'(x) + 64'(c);
        return {(t > 64'hFFFF), t[15:0]};
    endfunction

    function automatic logic [31:0] sat(input int n);
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    task automatic passo();
        @(posedge ck);
        #1;
    endtask

    task automatic modelo_coef(input logic [1:0] sel, input logic [15:0] val);
        case (sel)
            2'd0:    ma = val;
            2'd1:    mb = val;
            2'd2:    mc = val;
            default: ;
        endcase
    endtask

    task automatic escreve(input logic [1:0] sel, input logic [15:0] val);
        bus.coef_we = 1'b1; bus.coef_sel = sel; bus.coef_dado = val;
        passo();
        bus.coef_we = 1'b0;
        modelo_coef(sel, val);
    endtask

    task automatic retira();
        chk("r_valid_head", 32'(bus.r_valid), 32'd1);
        chk("r_dado_head", 32'(bus.r_dado), 32'(fila[0][15:0]));
        chk("r_ovf_head", 32'(bus.r_ovf), 32'(fila[0][16]));
        bus.r_ready = 1'b1;
        passo();
        bus.r_ready = 1'b0;
        void'(fila.pop_front());
    endtask

    // One full transaction: offer sample, play evaluator, check the pushed result.
    task automatic avalia(input logic [15:0] xv, input logic wr, input logic [1:0] sel,
                          input logic [15:0] val, input int lat, input logic usa_forca,
                          input logic [16:0] forca, input logic manter, input logic coef_espera);
        int k;
        logic [16:0] r, esp;
        k = 0;
        bus.x_valid = 1'b1; bus.x_dado = xv;
        while (bus.x_ready !== 1'b1 && k < 40) begin passo(); k++; end
        chk("accept_timeout", 32'(k < 40), 32'd1);
        bus.coef_we = wr; bus.coef_sel = sel; bus.coef_dado = val;
        passo();
        bus.x_valid = 1'b0; bus.coef_we = 1'b0;
        if (wr) modelo_coef(sel, val);
        chk("inicio_dispara", 32'(bus.inicio), 32'd1);
        chk("ocupado_dispara", 32'(bus.ocupado), 32'd1);
        chk("x_ready_dispara", 32'(bus.x_ready), 32'd0);
        chk("X_latched", 32'(bus.X), 32'(xv));
        chk("A_op", 32'(bus.A), 32'(ma));
        chk("B_op", 32'(bus.B), 32'(mb));
        chk("C_op", 32'(bus.C), 32'(mc));
        passo();
        chk("inicio_espera", 32'(bus.inicio), 32'd0);
        if (bus.pronto === 1'b1) begin
            repeat (3) begin
                passo();
                chk("pronto_high_no_capture", 32'(bus.contagem), sat(n_aval));
                chk("pronto_high_busy", 32'(bus.ocupado), 32'd1);
            end
            bus.pronto = 1'b0;
            passo();
        end
        if (coef_espera) begin
            bus.coef_we = 1'b1; bus.coef_sel = 2'd0; bus.coef_dado = 16'h0005;
            passo();
            bus.coef_we = 1'b0;
        end
        for (int i = 0; i < lat; i++) begin
            passo();
            chk("X_stable", 32'(bus.X), 32'(xv));
            chk("inicio_low", 32'(bus.inicio), 32'd0);
        end
        esp = usa_forca ? forca : poli(xv, ma, mb, mc);
        r   = usa_forca ? forca : poli(bus.X, bus.A, bus.B, bus.C);
        bus.pronto = 1'b1; bus.resultado = r[15:0]; bus.overflow = r[16];
        passo();
        if (!manter) bus.pronto = 1'b0;
        chk("ocupado_grava", 32'(bus.ocupado), 32'd1);
        chk("x_ready_grava", 32'(bus.x_ready), 32'd0);
        chk("inicio_grava", 32'(bus.inicio), 32'd0);
        passo();
        fila.push_back(esp);
        n_aval++;
        chk("contagem", 32'(bus.contagem), sat(n_aval));
        chk("r_valid_after_push", 32'(bus.r_valid), 32'd1);
        chk("ocupado_idle", 32'(bus.ocupado), 32'd0);
        chk("A_after", 32'(bus.A), 32'(ma));
        if (fila.size() == 1) chk("r_dado_latency", 32'(bus.r_dado), 32'(esp[15:0]));
    endtask

    initial begin
        rst = 1'b1;
        bus.coef_we = 1'b0; bus.coef_sel = 2'd0; bus.coef_dado = 16'd0;
        bus.x_valid = 1'b0; bus.x_dado = 16'd0;
        bus.pronto = 1'b0; bus.overflow = 1'b0; bus.resultado = 16'd0;
        bus.r_ready = 1'b0;
        ma = 16'd0; mb = 16'd0; mc = 16'd0;
        repeat (2) @(posedge ck);
        #1;
        chk("rst_inicio", 32'(bus.inicio), 32'd0);
        chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
        chk("rst_contagem", 32'(bus.contagem), 32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_X", 32'(bus.X), 32'd0);
        rst = 1'b0;
        chk("rst_x_ready", 32'(bus.x_ready), 32'd1);

        // Basic evaluation: 1*4 + 2*2 + 3 = 11
        escreve(2'd0, 16'd1); escreve(2'd1, 16'd2); escreve(2'd2, 16'd3);
        escreve(2'd3, 16'hFFFF);
        chk("sel3_A", 32'(bus.A), 32'd1);
        chk("sel3_C", 32'(bus.C), 32'd3);
        avalia(16'd2, 1'b0, 2'd0, 16'd0, 1, 1'b0, 17'd0, 1'b0, 1'b0);
        chk("basic_r_dado", 32'(bus.r_dado), 32'h000B);
        chk("basic_r_ovf", 32'(bus.r_ovf), 32'd0);
        chk("basic_contagem", 32'(bus.contagem), 32'd1);
        retira();

        // Evaluator-reported overflow passes through untouched
        avalia(16'd7, 1'b0, 2'd0, 16'd0, 2, 1'b1, {1'b1, 16'h1234}, 1'b0, 1'b0);
        chk("ovf_r_ovf", 32'(bus.r_ovf), 32'd1);
        chk("ovf_r_dado", 32'(bus.r_dado), 32'h1234);
        retira();

        // Coefficient written on the accept edge is used by that evaluation
        avalia(16'd5, 1'b1, 2'd1, 16'd7, 0, 1'b0, 17'd0, 1'b0, 1'b0);
        retira();

        // Write during ESPERA ignored; write back in idle succeeds
        avalia(16'd4, 1'b0, 2'd0, 16'd0, 1, 1'b0, 17'd0, 1'b0, 1'b1);
        retira();
        escreve(2'd0, 16'h0005);
        chk("A_write_idle", 32'(bus.A), 32'h0005);

        // Full FIFO backpressure and order
        avalia(16'd10, 1'b0, 2'd0, 16'd0, 1, 1'b0, 17'd0, 1'b0, 1'b0);
        avalia(16'd11, 1'b0, 2'd0, 16'd0, 0, 1'b0, 17'd0, 1'b0, 1'b0);
        bus.x_valid = 1'b1; bus.x_dado = 16'd12;
        repeat (2) begin
            passo();
            chk("full_x_ready", 32'(bus.x_ready), 32'd0);
            chk("full_idle", 32'(bus.ocupado), 32'd0);
        end
        retira();
        chk("after_pop_x_ready", 32'(bus.x_ready), 32'd1);
        avalia(16'd12, 1'b0, 2'd0, 16'd0, 1, 1'b0, 17'd0, 1'b0, 1'b0);
        retira(); retira();

        // Reset during ESPERA with one result still queued
        avalia(16'd3, 1'b0, 2'd0, 16'd0, 1, 1'b0, 17'd0, 1'b0, 1'b0);
        bus.x_valid = 1'b1; bus.x_dado = 16'd9;
        passo();
        bus.x_valid = 1'b0;
        chk("pre_rst_inicio", 32'(bus.inicio), 32'd1);
        passo();
        chk("pre_rst_busy", 32'(bus.ocupado), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_inicio", 32'(bus.inicio), 32'd0);
        chk("arst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("arst_r_valid", 32'(bus.r_valid), 32'd0);
        chk("arst_r_dado", 32'(bus.r_dado), 32'd0);
        chk("arst_r_ovf", 32'(bus.r_ovf), 32'd0);
        chk("arst_contagem", 32'(bus.contagem), 32'd0);
        chk("arst_XA", 32'({bus.X, bus.A}), 32'd0);
        chk("arst_BC", 32'({bus.B, bus.C}), 32'd0);
        bus.pronto = 1'b1;
        passo(); passo();
        rst = 1'b0;
        bus.pronto = 1'b0;
        ma = 16'd0; mb = 16'd0; mc = 16'd0;
        fila.delete();
        n_aval = 0;
        chk("post_rst_x_ready", 32'(bus.x_ready), 32'd1);
        chk("post_rst_r_valid", 32'(bus.r_valid), 32'd0);
        chk("post_rst_contagem", 32'(bus.contagem), 32'd0);

        // Random traffic past the counter saturation point
        for (int i = 0; i < 262; i++) begin
            if ($urandom_range(0, 3) == 0) escreve(2'($urandom_range(0, 3)), 16'($urandom));
            avalia(16'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                   int'($urandom_range(0, 3)), 1'b0, 17'd0, (i == 100), 1'b0);
            if (fila.size() == 2 || $urandom_range(0, 1) == 1) retira();
        end
        while (fila.size() > 0) retira();
        chk("contagem_saturated", 32'(bus.contagem), 32'd255);
        chk("drained_r_valid", 32'(bus.r_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
